output_collector: RTL and testbench
===================================

OUTPUT_COLLECTOR -- requirements
Module: output_collector

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entry count; power of two, 4..64.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  execute-stage output strobe (out_valid).
REQ-005 SHALL have port in_data  input  3  execute-stage output digit (reg_out[2:0]).
REQ-006 SHALL have port prog_halt  input  1  execute-stage halt indication.
REQ-007 SHALL have port host_ready  input  1  host accepts dout this cycle.
REQ-008 SHALL have port dout  output  3  head-of-FIFO digit.
REQ-009 SHALL have port dout_valid  output  1  dout holds a valid digit.
REQ-010 SHALL have port count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-011 SHALL have port overflow  output  1  sticky: a digit was dropped.
REQ-012 SHALL have port done  output  1  program halted and all digits delivered.
REQ-013 SHALL have port checksum  output  8  running checksum of accepted digits.

Function
REQ-014 Push: in_valid=1 in state RUN or DRAIN and (count<DEPTH or pop this cycle) -> in_data written at tail.
REQ-015 Push when full with no pop -> digit dropped, overflow set, count unchanged.
REQ-016 Pop: dout_valid=1 and host_ready=1 -> head retired at clock edge.
REQ-017 Show-ahead: dout/dout_valid combinational from head; dout_valid = (count!=0).
REQ-018 Latency: digit pushed into empty FIFO at edge N visible on dout with dout_valid=1 after edge N.
REQ-019 Simultaneous push+pop: count unchanged; full-with-pop accepts the push, no overflow.
REQ-020 dout SHALL be held stable while dout_valid=1 and host_ready=0.
REQ-021 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.
REQ-022 FSM states RUN, DRAIN, DONE; reset state RUN.
REQ-023 RUN -> DRAIN on prog_halt=1; a digit with in_valid in that same cycle is still accepted.
REQ-024 DRAIN -> DONE when count==0 and no push this cycle; DRAIN with count==0 at entry -> DONE next edge.
REQ-025 DONE: in_valid ignored (no push, no overflow); held until reset.
REQ-026 done = (state==DONE), registered.

Reset
REQ-027 rst=1 asynchronously: pointers=0, count=0, dout_valid=0, dout=0, overflow=0, done=0, checksum=0, state=RUN.
REQ-028 Reset mid-operation SHALL discard all buffered digits; first post-reset push treated as into empty FIFO.

Configuration
REQ-029 Macro OUT_CHECKSUM_EN defined: per accepted push, checksum <= {checksum[4:0],checksum[7:5]} ^ {5'b0,in_data}.
REQ-030 Macro OUT_CHECKSUM_EN undefined: checksum port present, tied to 8'd0; no checksum register.

Structure
REQ-031 Shared package SHALL hold FSM state encodings (RUN=2'd0, DRAIN=2'd1, DONE=2'd2), default DEPTH, and digit width constant (3).
REQ-032 Storage and pointers SHALL be in sub-module output_fifo_mem (write-port, read-head, wrap logic); FSM, flags, checksum in top.

Verification
REQ-033 Push 5,3,0 on consecutive cycles, host_ready=1 -> dout 5,3,0 on consecutive cycles, count peaks at 1, no overflow.
REQ-034 host_ready=0, push DEPTH+2 digits -> count=DEPTH, overflow=1, last two digits absent when drained.
REQ-035 Full FIFO, push 7 and pop same cycle -> count stays DEPTH, overflow stays 0, 7 is last digit read.
REQ-036 Push 2,4, then prog_halt=1, host_ready=1 -> DRAIN, done=1 one edge after count reaches 0; later in_valid ignored.
REQ-037 rst pulse with count=6, mid-cycle -> count=0, dout_valid=0, overflow=0, done=0 immediately.
REQ-038 OUT_CHECKSUM_EN defined, push 1,2,3 -> checksum 8'h00->8'h01->8'h0A->8'h53; undefined -> checksum 0 throughout.

Source files
------------

// File: rtl/output_collector_pkg.sv
// output_collector_pkg: shared constants for the output collector (FSM encodings, default depth, digit width).
`default_nettype none

package output_collector_pkg;

  localparam int DEFAULT_DEPTH = 16;
  localparam int DIGIT_W       = 3;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/output_fifo_mem.sv
// output_fifo_mem: digit storage with wrapping write/read pointers and occupancy count.
`default_nettype none

module output_fifo_mem
  import output_collector_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [DIGIT_W-1:0] wr_data,
  input  logic               rd_en,
  output logic [DIGIT_W-1:0] rd_data,
  output logic [CW-1:0]      count
);

  logic [DIGIT_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;

  // Storage needs no reset: only entries behind a live pointer are ever observed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so the natural pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/output_collector.sv
// output_collector: show-ahead FIFO between execute stage and host, with RUN/DRAIN/DONE sequencing.
// Optional running checksum of accepted digits enabled by macro OUT_CHECKSUM_EN.
`default_nettype none

module output_collector
  import output_collector_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [DIGIT_W-1:0] in_data,
  input  logic               prog_halt,
  input  logic               host_ready,
  output logic [DIGIT_W-1:0] dout,
  output logic               dout_valid,
  output logic [CW-1:0]      count,
  output logic               overflow,
  output logic               done,
  output logic [7:0]         checksum
);

  logic [1:0]         state;
  logic [DIGIT_W-1:0] head;
  logic               pop;
  logic               full;
  logic               active;
  logic               push;
  logic               drop;

  assign dout_valid = (count != '0);
  assign dout       = dout_valid ? head : '0;
  assign pop        = dout_valid & host_ready;
  assign full       = (count == CW'(DEPTH));
  assign active     = (state != ST_DONE);
  // A full FIFO still accepts a digit when the head retires on the same edge.
  assign push       = in_valid & active & (~full | pop);
  assign drop       = in_valid & active & full & ~pop;

  output_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (in_data),
    .rd_en   (pop),
    .rd_data (head),
    .count   (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (prog_halt) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if ((count == '0) && !push) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_DONE;
        default: state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

  assign done = (state == ST_DONE);

`ifdef OUT_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum <= 8'd0;
    end else if (push) begin
      csum <= {csum[4:0], csum[7:5]} ^ {5'b0, in_data};
    end
  end

  assign checksum = csum;
`else
  assign checksum = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_output_collector.sv
// tb_output_collector: randomized and directed checks of output_collector against a queue-based reference model.
`default_nettype none

module tb_output_collector;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [2:0]    in_data;
  logic          prog_halt;
  logic          host_ready;
  logic [2:0]    dout;
  logic          dout_valid;
  logic [CW-1:0] count;
  logic          overflow;
  logic          done;
  logic [7:0]    checksum;

  output_collector #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .prog_halt  (prog_halt),
    .host_ready (host_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .count      (count),
    .overflow   (overflow),
    .done       (done),
    .checksum   (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model: digits in arrival order plus the sequencing flags.
  int         q[$];
  bit         m_halted;
  bit         m_done;
  bit         m_ovf;
  logic [7:0] m_cs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int exp_dout;
    exp_dout = (q.size() != 0) ? q[0] : 0;
    check({tag, ".dout_valid"}, 32'(dout_valid), 32'(q.size() != 0));
    check({tag, ".dout"},       32'(dout),       32'(exp_dout));
    check({tag, ".count"},      32'(count),      32'(q.size()));
    check({tag, ".overflow"},   32'(overflow),   32'(m_ovf));
    check({tag, ".done"},       32'(done),       32'(m_done));
    check({tag, ".checksum"},   32'(checksum),   32'(m_cs));
  endtask

  task automatic model_reset();
    q.delete();
    m_halted = 0;
    m_done   = 0;
    m_ovf    = 0;
    m_cs     = 8'd0;
  endtask

  task automatic model_edge(input bit v, input logic [2:0] d, input bit h, input bit r);
    bit pop;
    bit acc;
    if (m_done) return;
    pop = (q.size() > 0) && r;
    acc = v && ((q.size() < DEPTH) || pop);
    if (v && !acc) m_ovf = 1;
    if (m_halted && (q.size() == 0) && !acc) m_done = 1;
    if (!m_halted && h) m_halted = 1;
    if (pop) void'(q.pop_front());
    if (acc) begin
      q.push_back(int'(d));
`ifdef OUT_CHECKSUM_EN
      m_cs = ((m_cs << 3) | (m_cs >> 5)) ^ {5'b0, d};
`endif
    end
  endtask

  task automatic step(input string tag, input bit v, input logic [2:0] d, input bit h, input bit r);
    in_valid   = v;
    in_data    = d;
    prog_halt  = h;
    host_ready = r;
    @(posedge clk);
    model_edge(v, d, h, r);
    #1;
    check_all(tag);
  endtask

  // Asserts reset between clock edges and checks the outputs clear before any edge.
  task automatic reset_pulse(input string tag);
    in_valid  = 1'b0;
    prog_halt = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all(tag);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] rnd_digit();
    return 3'($urandom_range(0, 7));
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = 3'd0;
    prog_halt  = 1'b0;
    host_ready = 1'b0;
    model_reset();
    #3;
    check_all("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Back-to-back digits with the host always ready.
    step("seq5", 1'b1, 3'd5, 1'b0, 1'b1);
    step("seq3", 1'b1, 3'd3, 1'b0, 1'b1);
    step("seq0", 1'b1, 3'd0, 1'b0, 1'b1);
    step("seqe", 1'b0, 3'd0, 1'b0, 1'b1);

    // Checksum sequence on known digits.
    reset_pulse("rst_cs");
    step("cs1", 1'b1, 3'd1, 1'b0, 1'b0);
`ifdef OUT_CHECKSUM_EN
    check("cs_after_1", 32'(checksum), 32'h01);
`else
    check("cs_after_1", 32'(checksum), 32'h00);
`endif
    step("cs2", 1'b1, 3'd2, 1'b0, 1'b0);
`ifdef OUT_CHECKSUM_EN
    check("cs_after_2", 32'(checksum), 32'h0A);
`else
    check("cs_after_2", 32'(checksum), 32'h00);
`endif
    step("cs3", 1'b1, 3'd3, 1'b0, 1'b0);
`ifdef OUT_CHECKSUM_EN
    check("cs_after_3", 32'(checksum), 32'h53);
`else
    check("cs_after_3", 32'(checksum), 32'h00);
`endif

    // Random traffic with no halt.
    for (int i = 0; i < 150; i++) begin
      step("rand", 1'($urandom_range(0, 1)), rnd_digit(), 1'b0, ($urandom_range(0, 3) != 0));
    end

    // Reset with six digits buffered.
    reset_pulse("rst_a");
    for (int i = 0; i < 6; i++) step("fill6", 1'b1, rnd_digit(), 1'b0, 1'b0);
    check("count6", 32'(count), 32'd6);
    reset_pulse("rst6");

    // Overfill with the host stalled, then drain.
    for (int i = 0; i < DEPTH + 2; i++) step("ovf_fill", 1'b1, rnd_digit(), 1'b0, 1'b0);
    check("ovf_count", 32'(count), 32'(DEPTH));
    check("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 0; i < DEPTH + 1; i++) step("ovf_drain", 1'b0, 3'd0, 1'b0, 1'b1);

    // Full FIFO with simultaneous push and pop.
    reset_pulse("rst_full");
    for (int i = 0; i < DEPTH; i++) step("full_fill", 1'b1, rnd_digit(), 1'b0, 1'b0);
    step("full_pp7", 1'b1, 3'd7, 1'b0, 1'b1);
    check("full_pp_count", 32'(count), 32'(DEPTH));
    for (int i = 0; i < DEPTH - 1; i++) step("full_drain", 1'b0, 3'd0, 1'b0, 1'b1);
    check("last_is_7", 32'(dout), 32'd7);
    step("full_last", 1'b0, 3'd0, 1'b0, 1'b1);

    // Halt and drain to DONE; later digits ignored.
    reset_pulse("rst_halt");
    step("h2", 1'b1, 3'd2, 1'b0, 1'b0);
    step("h4", 1'b1, 3'd4, 1'b0, 1'b0);
    step("halt", 1'b0, 3'd0, 1'b1, 1'b1);
    for (int i = 0; i < 10 && !m_done; i++) step("drain", 1'b0, 3'd0, 1'b0, 1'b1);
    check("done_reached", 32'(done), 32'd1);
    for (int i = 0; i < 5; i++) step("done_ign", 1'b1, rnd_digit(), 1'b0, 1'($urandom_range(0, 1)));

    // Halt with an empty FIFO finishes one edge after entering DRAIN.
    reset_pulse("rst_empty");
    step("halt_empty", 1'b0, 3'd0, 1'b1, 1'b1);
    step("empty_done", 1'b0, 3'd0, 1'b0, 1'b1);

    // Random traffic with occasional halt, up to DONE.
    reset_pulse("rst_rh");
    for (int i = 0; i < 120; i++) begin
      step("rand_halt", 1'($urandom_range(0, 1)), rnd_digit(), ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 2) != 0));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
